// File: rtl/event_trigger_bank.sv
// Multi-channel event trigger bank: immediate or DELAY-deferred trigger requests
// fire a registered pulse, a toggle and a saturating counter with sticky status flags.
module event_trigger_bank #(
    parameter int NUM_CH = 4,
    parameter int DELAY  = 1,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         trig_valid,
    input  logic [NUM_CH-1:0]         trig_defer,
    input  logic                      clr_cnt,
    output logic [NUM_CH-1:0]         event_pulse,
    output logic [NUM_CH-1:0]         event_toggle,
    output logic [NUM_CH*CNT_W-1:0]   event_cnt,
    output logic [NUM_CH-1:0]         cnt_ovf,
    output logic [NUM_CH-1:0]         coalesced,
    output logic                      any_event
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NUM_CH-1:0][DELAY-1:0] dly_q, dly_d;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic [NUM_CH-1:0]            pulse_q, pulse_d;
    logic [NUM_CH-1:0]            toggle_q, toggle_d;
    logic [NUM_CH-1:0]            ovf_q, ovf_d;
    logic [NUM_CH-1:0]            coal_q, coal_d;
    logic [NUM_CH-1:0]            imm, matured, fire;

    // Each delay line shifts every edge, so back-to-back deferred requests stay
    // in separate stages and can never merge while in flight.
    always_comb begin
        dly_d   = '0;
        matured = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            matured[i]  = dly_q[i][DELAY-1];
            dly_d[i][0] = trig_valid[i] & trig_defer[i];
            for (int j = 1; j < DELAY; j++) begin
                dly_d[i][j] = dly_q[i][j-1];
            end
        end
    end

    assign imm  = trig_valid & ~trig_defer;
    assign fire = imm | matured;

    // Clear takes effect before this edge's fire is applied, so a fire on the
    // clearing edge leaves the counter at one rather than zero.
    always_comb begin
        cnt_base = '0;
        cnt_d    = '0;
        ovf_d    = '0;
        coal_d   = '0;
        pulse_d  = fire;
        toggle_d = toggle_q ^ fire;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_base[i] = clr_cnt ? '0 : cnt_q[i];
            ovf_d[i]    = clr_cnt ? 1'b0 : ovf_q[i];
            coal_d[i]   = (clr_cnt ? 1'b0 : coal_q[i]) | (imm[i] & matured[i]);
            cnt_d[i]    = cnt_base[i];
            if (fire[i]) begin
                if (cnt_base[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_base[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q    <= '0;
            cnt_q    <= '0;
            pulse_q  <= '0;
            toggle_q <= '0;
            ovf_q    <= '0;
            coal_q   <= '0;
        end else begin
            dly_q    <= dly_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            toggle_q <= toggle_d;
            ovf_q    <= ovf_d;
            coal_q   <= coal_d;
        end
    end

    assign event_pulse  = pulse_q;
    assign event_toggle = toggle_q;
    assign event_cnt    = cnt_q;
    assign cnt_ovf      = ovf_q;
    assign coalesced    = coal_q;
    assign any_event    = |pulse_q;

endmodule
